// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator and its fade sequencer:
// FSM state encoding and the threshold full-scale value.
package pwm_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_RAMP_UP   = 3'd1;
   localparam logic [2:0] ST_HOLD_HIGH = 3'd2;
   localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
   localparam logic [2:0] ST_HOLD_LOW  = 3'd4;

   typedef enum logic [2:0] {
      IDLE      = ST_IDLE,
      RAMP_UP   = ST_RAMP_UP,
      HOLD_HIGH = ST_HOLD_HIGH,
      RAMP_DOWN = ST_RAMP_DOWN,
      HOLD_LOW  = ST_HOLD_LOW
   } fade_state_t;

   // All-ones threshold is 100 % duty in the PWM generator.
   function automatic int unsigned full_scale(input int unsigned nbits);
      return (32'd1 << nbits) - 32'd1;
   endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Free-running step divider: one-cycle tick every STEP_CYCLES enabled
// cycles; clear forces the count back to zero.
module step_tick_gen #(
   parameter int STEP_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(STEP_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         if (tick) cnt <= '0;
         else      cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Breathing sequencer: ramps the PWM threshold 0 -> MAX -> 0 with holds
// at both ends, once per start or looping while continuous is set.
module pwm_fade_ctrl
   import pwm_pkg::*;
#(
   parameter int THRESHOLD_NBITS = 4,
   parameter int STEP_CYCLES     = 1000000,
   parameter int HOLD_STEPS      = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       continuous,
   output logic [THRESHOLD_NBITS-1:0] threshold,
   output logic                       busy,
   output logic                       done
);

   localparam int TW = THRESHOLD_NBITS;
   localparam logic [TW-1:0] MAX = TW'(full_scale(THRESHOLD_NBITS));
   localparam logic [TW-1:0] MAX_M1 = MAX - TW'(1);
   localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
   localparam logic [HW-1:0] HLAST = HW'(HOLD_STEPS - 1);

   fade_state_t   state;
   logic [HW-1:0] hold_cnt;
   logic          tick;
   logic          tick_en;
   logic          tick_clear;
   logic          hold_last;

   // Divider idles at zero, so every launch from IDLE starts a full period.
   assign tick_en    = (state != IDLE);
   assign tick_clear = (state == IDLE) || stop;
   assign hold_last  = (hold_cnt == HLAST);

   step_tick_gen #(
      .STEP_CYCLES(STEP_CYCLES)
   ) u_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .clear(tick_clear),
      .en   (tick_en),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         threshold <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         hold_cnt  <= '0;
      end else begin
         done <= 1'b0;
         if (stop && state != IDLE) begin
            state     <= IDLE;
            threshold <= '0;
            busy      <= 1'b0;
            hold_cnt  <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  threshold <= '0;
                  hold_cnt  <= '0;
                  if (start && !stop) begin
                     state <= RAMP_UP;
                     busy  <= 1'b1;
                  end
               end
               RAMP_UP: begin
                  if (tick) begin
                     threshold <= threshold + TW'(1);
                     if (threshold == MAX_M1) begin
                        state    <= HOLD_HIGH;
                        hold_cnt <= '0;
                     end
                  end
               end
               HOLD_HIGH: begin
                  if (tick) begin
                     if (hold_last) begin
                        state    <= RAMP_DOWN;
                        hold_cnt <= '0;
                     end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                     end
                  end
               end
               RAMP_DOWN: begin
                  if (tick) begin
                     threshold <= threshold - TW'(1);
                     if (threshold == TW'(1)) begin
                        state    <= HOLD_LOW;
                        hold_cnt <= '0;
                     end
                  end
               end
               HOLD_LOW: begin
                  if (tick) begin
                     if (hold_last) begin
                        hold_cnt <= '0;
                        if (continuous) begin
                           state <= RAMP_UP;
                        end else begin
                           state <= IDLE;
                           busy  <= 1'b0;
                           done  <= 1'b1;
                        end
                     end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                     end
                  end
               end
               default: begin
                  state     <= IDLE;
                  threshold <= '0;
                  busy      <= 1'b0;
                  hold_cnt  <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/pwm_fade_ctrl.md
# pwm_fade_ctrl

Sequencer that drives the threshold input of the team's N-bit PWM generator to make a "breathing" output. It ramps the duty cycle from 0 to full scale, holds, ramps back to 0, and holds again, at a programmable step rate. It runs one breath per start request or loops continuously, with start/stop control and busy/done status. It sits between the board-level control (buttons/switches) and the PWM generator, in the same clock domain as the PWM counter.

## Interface
- THRESHOLD_NBITS, 4, width of threshold; full scale MAX = 2^THRESHOLD_NBITS − 1 (all-ones gives 100 % duty in the PWM generator)
- STEP_CYCLES, 1000000, clk cycles per ramp step (10 ms at 100 MHz); legal range ≥ 2
- HOLD_STEPS, 8, number of step periods spent in each hold state; legal range ≥ 1
- clk  input  1  system clock (PLL output domain)
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request to begin a breath
- stop  input  1  single-cycle abort request
- continuous  input  1  sampled when HOLD_LOW ends: 1 = loop back to RAMP_UP, 0 = finish
- threshold  output  THRESHOLD_NBITS  duty-cycle threshold to the PWM generator, registered
- busy  output  1  high in every state except IDLE, registered
- done  output  1  one-cycle pulse on normal completion, registered

## Operation
- The FSM has 5 states: IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW.
- Step tick: a counter runs 0..STEP_CYCLES−1 while not IDLE and asserts tick when the count is STEP_CYCLES−1; the counter is cleared on every state entry from IDLE.
- Hold counter: counts ticks in HOLD_HIGH and HOLD_LOW, and is cleared on entry to either state.
- IDLE: threshold = 0, busy = 0. On start (and no stop), go to RAMP_UP.
- RAMP_UP: on tick, threshold += 1. On the tick where threshold becomes MAX, go to HOLD_HIGH.
- HOLD_HIGH: threshold stays at MAX. On the HOLD_STEPS-th tick, go to RAMP_DOWN.
- RAMP_DOWN: on tick, threshold −= 1. On the tick where threshold becomes 0, go to HOLD_LOW.
- HOLD_LOW: threshold stays at 0. On the HOLD_STEPS-th tick:
  - if continuous = 1, go to RAMP_UP;
  - otherwise go to IDLE and pulse done.
- Threshold never wraps. It is bounded to 0..MAX by construction.
- Boundary cases:
  - stop in any non-IDLE state: the next cycle is IDLE with threshold = 0, counters cleared, and no done pulse.
  - start and stop in the same cycle: stop wins.
  - start while busy: ignored. stop in IDLE: ignored.
  - continuous changing mid-breath: has no effect until the end of HOLD_LOW.
  - rst_n asserted mid-operation: all outputs and state return to reset values immediately.

## Timing
- Reset values: state IDLE, threshold 0, busy 0, done 0, both counters 0.
- start sampled high at edge k: busy = 1 and state = RAMP_UP after edge k.
- The first tick occurs STEP_CYCLES cycles after entry to RAMP_UP. Each threshold update is visible right after the tick edge.
- Breath length, from RAMP_UP entry to return to IDLE: (2·MAX + 2·HOLD_STEPS) · STEP_CYCLES cycles.
- done is high for exactly the first IDLE cycle. busy falls on the same edge that done rises.
- In continuous mode, the transition HOLD_LOW → RAMP_UP has no idle gap, and the step period stays uninterrupted.
- Latency from stop to threshold = 0 / busy = 0: 1 cycle.

## Structure
- Shared package/header pwm_pkg holds:
  - the state encoding localparams (IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW);
  - the MAX computation, shared with the PWM generator so threshold full scale stays consistent.
- One sub-module is natural: step_tick_gen (parameter STEP_CYCLES; ports clk, rst_n, clear, en, tick). It uses a counter of width $clog2(STEP_CYCLES).
- The FSM, hold counter and threshold register live in the top module.

## Test plan
All scenarios use THRESHOLD_NBITS=4, STEP_CYCLES=4, HOLD_STEPS=2 unless stated otherwise.
- Reset: assert rst_n=0 mid-RAMP_UP with threshold=7 -> threshold=0, busy=0, done=0 immediately; IDLE after release.
- Single breath:
  - stimulus: start pulse, continuous=0;
  - threshold steps 0→15 every 4 cycles, then holds 15 for 8 cycles, steps 15→0, holds 0 for 8 cycles;
  - done pulses exactly 136 cycles after RAMP_UP entry; busy is low afterwards.
- Continuous: continuous=1 for 3 breaths, then 0 -> no idle gap between breaths, exactly one done pulse, at cycle 408.
- Abort: stop during HOLD_HIGH -> next cycle IDLE, threshold=0, no done; a following start restarts cleanly from threshold 0.
- Collisions:
  - start+stop in the same IDLE cycle -> stays IDLE;
  - start during RAMP_DOWN -> ignored, waveform unchanged.
- Scaling: THRESHOLD_NBITS=8, STEP_CYCLES=2, HOLD_STEPS=1 -> threshold peaks at 255, never wraps; breath takes 1024 cycles.
